branch_resolve_controller: RTL and testbench

BRANCH_RESOLVE_CONTROLLER -- requirements
Module: branch_resolve_controller

---
 rtl/branch_resolve_controller.sv | 150 +++++++++++++++
 tb/tb_branch_resolve_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_controller.sv
// Branch resolution controller: captures one branch, evaluates it the next cycle,
// redirects fetch and holds flush when taken. Optional statistics under BRANCH_STATS_EN.
module branch_resolve_controller #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  funct3,
    input  logic [63:0] op_a,
    input  logic [63:0] op_b,
    input  logic [63:0] pc,
    input  logic [63:0] imm,
    output logic        result_valid,
    output logic        taken,
    output logic        illegal,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        flush,
    output logic        stall,
    output logic [31:0] br_count,
    output logic [31:0] taken_count
);
    typedef enum logic [1:0] {IDLE, EVAL, FLUSH} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [63:0] op_a_q, op_a_d;
    logic [63:0] op_b_q, op_b_d;
    logic [63:0] target_q, target_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        cond;
    logic        bad_f3;

    always_comb begin
        cond   = 1'b0;
        bad_f3 = 1'b0;
        unique case (funct3_q)
            3'b000:  cond = (op_a_q == op_b_q);
            3'b001:  cond = (op_a_q != op_b_q);
            3'b100:  cond = ($signed(op_a_q) <  $signed(op_b_q));
            3'b101:  cond = ($signed(op_a_q) >= $signed(op_b_q));
            3'b110:  cond = (op_a_q <  op_b_q);
            3'b111:  cond = (op_a_q >= op_b_q);
            default: bad_f3 = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (br_valid) begin
                    funct3_d = funct3;
                    op_a_d   = op_a;
                    op_b_d   = op_b;
                    target_d = (pc + imm) & ~64'd1;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                state_d = IDLE;
                // A single-cycle flush is fully covered by the EVAL cycle itself.
                if (cond && (FLUSH_CYCLES > 1)) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            funct3_q <= 3'd0;
            op_a_q   <= 64'd0;
            op_b_q   <= 64'd0;
            target_q <= 64'd0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        br_ready       = (state_q == IDLE);
        result_valid   = (state_q == EVAL);
        taken          = result_valid && cond;
        illegal        = result_valid && bad_f3;
        redirect_valid = taken;
        redirect_pc    = redirect_valid ? target_q : 64'd0;
        flush          = taken || (state_q == FLUSH);
        stall          = (state_q != IDLE);
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] taken_count_q, taken_count_d;

    always_comb begin
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;
        if (result_valid && (br_count_q != 32'hFFFF_FFFF)) begin
            br_count_d = br_count_q + 32'd1;
        end
        if (taken && (taken_count_q != 32'hFFFF_FFFF)) begin
            taken_count_d = taken_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_count_q    <= 32'd0;
            taken_count_q <= 32'd0;
        end else begin
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign br_count    = br_count_q;
    assign taken_count = taken_count_q;
`else
    assign br_count    = 32'd0;
    assign taken_count = 32'd0;
`endif
endmodule

// File: tb/tb_branch_resolve_controller.sv
// Scoreboard bench for branch_resolve_controller: driver pushes model predictions,
// a negedge monitor pops and compares on every result_valid.
module tb_branch_resolve_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, reset4, br_valid, br_valid4;
    logic [2:0]  funct3;
    logic [63:0] op_a, op_b, pc, imm;

    logic        br_ready, result_valid, taken, illegal, redirect_valid, flush, stall;
    logic [63:0] redirect_pc;
    logic [31:0] br_count, taken_count;
    logic        br_ready4, result_valid4, taken4, illegal4, redirect_valid4, flush4, stall4;
    logic [63:0] redirect_pc4;
    logic [31:0] br_count4, taken_count4;

    branch_resolve_controller #(.FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_ready(br_ready),
        .funct3(funct3), .op_a(op_a), .op_b(op_b), .pc(pc), .imm(imm),
        .result_valid(result_valid), .taken(taken), .illegal(illegal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .stall(stall), .br_count(br_count), .taken_count(taken_count)
    );

    branch_resolve_controller #(.FLUSH_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset4), .br_valid(br_valid4), .br_ready(br_ready4),
        .funct3(funct3), .op_a(op_a), .op_b(op_b), .pc(pc), .imm(imm),
        .result_valid(result_valid4), .taken(taken4), .illegal(illegal4),
        .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
        .flush(flush4), .stall(stall4), .br_count(br_count4), .taken_count(taken_count4)
    );

    typedef struct {
        logic        tk;
        logic        il;
        logic [63:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   model_br = 0;
    int   model_tk = 0;
    int   flush_run = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: RISC-V branch semantics straight from the funct3 table.
    function automatic exp_t model(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] p, input logic [63:0] i);
        exp_t e;
        e.il  = (f3 == 3'b010) || (f3 == 3'b011);
        e.tgt = (p + i) & ~64'd1;
        case (f3)
            3'b000:  e.tk = (a == b);
            3'b001:  e.tk = (a != b);
            3'b100:  e.tk = ($signed(a) <  $signed(b));
            3'b101:  e.tk = ($signed(a) >= $signed(b));
            3'b110:  e.tk = (a <  b);
            3'b111:  e.tk = (a >= b);
            default: e.tk = 1'b0;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            model_br  = 0;
            model_tk  = 0;
            flush_run = 0;
        end else begin
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("taken", taken, mon_e.tk);
                    chk("illegal", illegal, mon_e.il);
                    chk("redirect_valid", redirect_valid, mon_e.tk);
                    chk("flush_in_eval", flush, mon_e.tk);
                    if (mon_e.tk) chk("redirect_pc", redirect_pc, mon_e.tgt);
                    model_br++;
                    if (mon_e.tk) model_tk++;
                end
            end
            if (flush) begin
                flush_run++;
            end else if (flush_run != 0) begin
                chk("flush_len", flush_run, 2);
                flush_run = 0;
            end
        end
    end

    task automatic send(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] p, input logic [63:0] i);
        int   n;
        exp_t e;
        funct3   = f3;
        op_a     = a;
        op_b     = b;
        pc       = p;
        imm      = i;
        br_valid = 1'b1;
        n = 0;
        while (!br_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("accept_timeout", 64'd0, 64'd1);
            br_valid = 1'b0;
            return;
        end
        e = model(f3, a, b, p, i);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        br_valid = 1'b0;
        funct3   = 3'($urandom);
        op_a     = {$urandom, $urandom};
        op_b     = {$urandom, $urandom};
        pc       = {$urandom, $urandom};
        imm      = {$urandom, $urandom};
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!br_ready && n < 50);
        chk("spacing", n, e.tk ? 3 : 2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          k;
        int          nf;
        logic [2:0]  f3;
        logic [63:0] a, b;
        reset = 1'b1; reset4 = 1'b1; br_valid = 1'b0; br_valid4 = 1'b0;
        funct3 = 3'd0; op_a = 64'd0; op_b = 64'd0; pc = 64'd0; imm = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; reset4 = 1'b0;
        @(negedge clk);
        chk("rst_br_ready", br_ready, 1);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_taken", taken, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_flush", flush, 0);
        chk("rst_stall", stall, 0);
        chk("rst_br_count", br_count, 0);
        chk("rst_taken_count", taken_count, 0);
        chk("rst4_br_ready", br_ready4, 1);

        send(3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8);
        send(3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8);
        send(3'b010, 64'd5, 64'd5, 64'h200, 64'h40);

        do_reset();
        for (int j = 0; j < 3; j++) send(3'b000, 64'd7 + 64'(j), 64'd7 + 64'(j), 64'h1000, 64'h10);
        for (int j = 0; j < 2; j++) send(3'b001, 64'd9, 64'd9, 64'h2000, 64'h20);
`ifdef BRANCH_STATS_EN
        chk("stats_br_count", br_count, 5);
        chk("stats_taken_count", taken_count, 3);
`else
        chk("stats_br_count", br_count, 0);
        chk("stats_taken_count", taken_count, 0);
`endif

        // FLUSH_CYCLES=4 instance: full flush length, then reset in first FLUSH cycle.
        funct3 = 3'b100; op_a = 64'hFFFF_FFFF_FFFF_FFFF; op_b = 64'd1; pc = 64'h100;
        imm = 64'hFFFF_FFFF_FFFF_FFF8;
        br_valid4 = 1'b1;
        @(posedge clk);
        #1;
        br_valid4 = 1'b0;
        nf = 0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (flush4) nf++;
        end while (!br_ready4 && k < 50);
        chk("dut4_flush_len", nf, 4);
        chk("dut4_spacing", k, 5);

        br_valid4 = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("dut4_eval_result_valid", result_valid4, 1);
        chk("dut4_eval_redirect_pc", redirect_pc4, 64'hF8);
        @(negedge clk);
        chk("dut4_flush1_flush", flush4, 1);
        chk("dut4_flush1_br_ready", br_ready4, 0);
        reset4 = 1'b1;
        @(posedge clk);
        #1;
        reset4 = 1'b0;
        br_valid4 = 1'b0;
        @(negedge clk);
        chk("dut4_rst_flush", flush4, 0);
        chk("dut4_rst_stall", stall4, 0);
        chk("dut4_rst_br_ready", br_ready4, 1);
        chk("dut4_rst_result_valid", result_valid4, 0);

        for (int j = 0; j < 150; j++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = ~a;
                2:       b = a ^ 64'h8000_0000_0000_0000;
                default: b = {$urandom, $urandom};
            endcase
            send(f3, a, b, {$urandom, $urandom}, {$urandom, $urandom});
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drain", exp_q.size(), 0);
`ifdef BRANCH_STATS_EN
        chk("final_br_count", br_count, model_br);
        chk("final_taken_count", taken_count, model_tk);
`else
        chk("final_br_count", br_count, 0);
        chk("final_taken_count", taken_count, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
